// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: FSM states, gain constant, arctangent table and
// the symmetric saturation helper used by polar_to_rect.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        DONE
    } state_t;

    // CORDIC gain compensation 1/An ~= 0.60725 in Q0.16.
    localparam int unsigned GAIN_K_Q16 = 39797;

    // atan(2^-k) in units of 2^-32 turn.
    localparam logic [31:0] ATAN_TABLE [32] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
    };

    // Gain constant rescaled to a Q0.w fraction.
    function automatic logic [31:0] gain_k(input int unsigned w);
        if (w >= 16)
            return GAIN_K_Q16 << (w - 16);
        else
            return GAIN_K_Q16 >> (16 - w);
    endfunction

    // Symmetric clamp to +/-(2^(w-1)-1); the most-negative code is excluded.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                    input int unsigned w);
        logic signed [31:0] lim;
        lim = (32'sd1 <<< (w - 1)) - 32'sd1;
        if (v > lim)
            return lim;
        else if (v < -lim)
            return -lim;
        else
            return v;
    endfunction

endpackage

// File: rtl/cordic_stage_mux.sv
// Per-iteration operand selection: arithmetic shifts of x/y and the
// width-bit arctangent entry for the current CORDIC step.
module cordic_stage_mux
    import cordic_pkg::*;
#(
    parameter int unsigned width = 16,
    parameter int unsigned cnt_w = 4
) (
    input  logic [cnt_w-1:0]       iter,
    input  logic signed [width+1:0] x,
    input  logic signed [width+1:0] y,
    output logic signed [width+1:0] x_shift,
    output logic signed [width+1:0] y_shift,
    output logic [width-1:0]       atan
);

    logic [4:0]  idx;
    logic [31:0] entry;

    always_comb begin
        idx     = 5'(iter);
        entry   = ATAN_TABLE[idx];
        x_shift = x >>> iter;
        y_shift = y >>> iter;
        atan    = width'(entry >> (32 - width));
    end

endmodule

// File: rtl/polar_to_rect.sv
// Iterative CORDIC polar-to-rectangular rotator with valid/ready on both sides.
// Optional: define POLAR_TO_RECT_SATURATE_EN to clamp outputs instead of wrapping.
module polar_to_rect
    import cordic_pkg::*;
#(
    parameter int unsigned width      = 16,
    parameter int unsigned iterations = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [width-2:0]        mag,
    input  logic [width-1:0]        phase,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [width-1:0] r,
    output logic signed [width-1:0] i
);

    localparam int unsigned cnt_w = (width > 2) ? $clog2(width) : 1;
    localparam int unsigned dw    = width + 2;
    localparam logic [cnt_w-1:0] last_iter = cnt_w'(iterations);
    localparam logic [width-1:0] gain      = width'(gain_k(width));

    state_t state, state_next;

    logic [cnt_w-1:0]        cnt;
    logic signed [dw-1:0]    x, y;
    logic [width-1:0]        z;

    logic [2*width-1:0]      prod;
    logic [width-1:0]        x_mag;
    logic signed [dw-1:0]    x_pos, x_start;
    logic [width-1:0]        z_start;
    logic                    quad;

    logic signed [dw-1:0]    x_shift, y_shift;
    logic [width-1:0]        atan;
    logic                    d;
    logic signed [dw-1:0]    x_next, y_next;
    logic [width-1:0]        z_next;
    logic signed [width-1:0] r_next, i_next;

    cordic_stage_mux #(
        .width (width),
        .cnt_w (cnt_w)
    ) u_stage (
        .iter    (cnt),
        .x       (x),
        .y       (y),
        .x_shift (x_shift),
        .y_shift (y_shift),
        .atan    (atan)
    );

    // Second and third quadrants are folded by a 180 degree turn: negate x, flip z MSB.
    always_comb begin
        prod    = {{(width+1){1'b0}}, mag} * {{width{1'b0}}, gain};
        x_mag   = width'(prod >> width);
        x_pos   = signed'({2'b00, x_mag});
        quad    = phase[width-1] ^ phase[width-2];
        x_start = quad ? -x_pos : x_pos;
        z_start = quad ? {~phase[width-1], phase[width-2:0]} : phase;
    end

    always_comb begin
        d = ~z[width-1];
        if (d) begin
            x_next = x - y_shift;
            y_next = y + x_shift;
            z_next = z - atan;
        end else begin
            x_next = x + y_shift;
            y_next = y - x_shift;
            z_next = z + atan;
        end
`ifdef POLAR_TO_RECT_SATURATE_EN
        r_next = width'(saturate(32'(x), width));
        i_next = width'(saturate(32'(y), width));
`else
        r_next = x[width-1:0];
        i_next = y[width-1:0];
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = ROTATE;
            end
            ROTATE: begin
                if (cnt == last_iter)
                    state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The cycle after the last micro-rotation registers the reduced result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x   <= '0;
            y   <= '0;
            z   <= '0;
            cnt <= '0;
            r   <= '0;
            i   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x   <= x_start;
                        y   <= '0;
                        z   <= z_start;
                        cnt <= '0;
                    end
                end
                ROTATE: begin
                    if (cnt == last_iter) begin
                        r <= r_next;
                        i <= i_next;
                    end else begin
                        x   <= x_next;
                        y   <= y_next;
                        z   <= z_next;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_polar_to_rect.sv
// Bench for polar_to_rect: vector table, hold/reset sequences and random
// samples against an ideal trigonometric model.
module tb_polar_to_rect;

    localparam int unsigned W   = 16;
    localparam int          LAT = 15;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [W-2:0]        mag;
    logic [W-1:0]        phase;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] r;
    logic signed [W-1:0] i;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int m;
        int p;
        int exp_r;
        int exp_i;
        int tol;
    } vec_t;

    vec_t tab [10];
    int   got_r_a [10];

    polar_to_rect #(
        .width      (W),
        .iterations (14)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mag       (mag),
        .phase     (phase),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .i         (i)
    );

    always #5 clk = ~clk;

    function automatic int out_diff(input int act, input int exp_v);
`ifdef POLAR_TO_RECT_SATURATE_EN
        int e;
        e = exp_v;
        if (e > 32767) e = 32767;
        if (e < -32767) e = -32767;
        return act - e;
`else
        int d;
        d = (act - exp_v) & 32'h0000_FFFF;
        if (d >= 32768) d = d - 65536;
        return d;
`endif
    endfunction

    task automatic check_near(input string name, input int act, input int exp_v, input int tol);
        int d;
        d = out_diff(act, exp_v);
        checks++;
        if (d > tol || d < -tol) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d +/- %0d", name, act, exp_v, tol);
        end
    endtask

    task automatic check_eq(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
        end
    endtask

    task automatic wait_in_ready(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({name, "_in_ready"}, int'(in_ready), 1);
    endtask

    task automatic run_one(input string name, input int m, input int p,
                           output int got_r, output int got_i);
        int lat;
        wait_in_ready(name);
        mag      = m[W-2:0];
        phase    = p[W-1:0];
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mag      = (W-1)'($urandom);
        phase    = W'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({name, "_latency"}, lat, LAT);
        got_r = int'(r);
        got_i = int'(i);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int gr, gi, n, bad, hr, hi, m, p, tol, er, ei;
        real ang;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mag       = '0;
        phase     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_in_ready",  int'(in_ready),  1);
        check_eq("reset_out_valid", int'(out_valid), 0);
        check_eq("reset_r",         int'(r),         0);
        check_eq("reset_i",         int'(i),         0);
        reset = 1'b0;
        @(posedge clk); #1;

        tab[0] = '{16384,     0,  16384,      0, 4};
        tab[1] = '{16384, 16384,      0,  16384, 4};
        tab[2] = '{16384, 32768, -16384,      0, 4};
        tab[3] = '{16384,  8192,  11585,  11585, 4};
        tab[4] = '{16384, 49152,      0, -16384, 4};
        tab[5] = '{16384, 24576, -11585,  11585, 4};
        tab[6] = '{    0, 12345,      0,      0, 0};
        tab[7] = '{32767,     0,  32767,      0, 4};
        tab[8] = '{32767, 32768, -32767,      0, 4};
        tab[9] = '{20000, 57344,  14142, -14142, 5};

        for (int k = 0; k < 10; k++) begin
            run_one($sformatf("vec%0d", k), tab[k].m, tab[k].p, gr, gi);
            got_r_a[k] = gr;
            check_near($sformatf("vec%0d_r", k), gr, tab[k].exp_r, tab[k].tol);
            check_near($sformatf("vec%0d_i", k), gi, tab[k].exp_i, tab[k].tol);
        end

`ifdef POLAR_TO_RECT_SATURATE_EN
        check_eq("fullscale_no_wrap",   int'(got_r_a[7] >= 0), 1);
        check_eq("fullscale_no_mincode", int'(got_r_a[8] != -32768), 1);
`endif

        // Stall the consumer: result must hold and in_valid must be ignored meanwhile.
        wait_in_ready("hold");
        mag      = 15'd16384;
        phase    = 16'd8192;
        in_valid = 1'b1;
        @(posedge clk); #1;
        mag   = 15'd1000;
        phase = 16'd40000;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("hold_latency", n, LAT);
        in_valid = 1'b0;
        hr  = int'(r);
        hi  = int'(i);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (int'(r) != hr || int'(i) != hi || !out_valid || in_ready)
                bad++;
        end
        check_eq("hold_stable", bad, 0);
        check_near("hold_r", hr, 11585, 4);
        check_near("hold_i", hi, 11585, 4);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("hold_released_out_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        check_eq("hold_released_in_ready", int'(in_ready), 1);

        // Reset in the middle of a rotation discards the sample.
        wait_in_ready("rst");
        mag      = 15'd20000;
        phase    = 16'd5000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("midrst_out_valid", int'(out_valid), 0);
        check_eq("midrst_in_ready",  int'(in_ready),  1);
        check_eq("midrst_r",         int'(r),         0);
        check_eq("midrst_i",         int'(i),         0);
        @(posedge clk); #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        out_ready = 1'b0;
        check_eq("midrst_no_emit", bad, 0);

        // Random samples against ideal polar-to-rectangular conversion.
        for (int k = 0; k < 30; k++) begin
            m   = int'($urandom_range(0, 30000));
            p   = int'($urandom_range(0, 65535));
            ang = real'(p) * 2.0 * 3.14159265358979 / 65536.0;
            er  = int'(real'(m) * $cos(ang));
            ei  = int'(real'(m) * $sin(ang));
            tol = 6 + m / 1024;
            run_one($sformatf("rnd%0d", k), m, p, gr, gi);
            check_near($sformatf("rnd%0d_r(m=%0d,p=%0d)", k, m, p), gr, er, tol);
            check_near($sformatf("rnd%0d_i(m=%0d,p=%0d)", k, m, p), gi, ei, tol);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
